// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the CPU core and a
// word-addressed data memory. Handles byte/halfword/word accesses,
// read-modify-write for sub-word stores, load extension and fault checks.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_ld_data,
  output logic        o_mem_w_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  input  logic [31:0] i_mem_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_wr, r_signed, r_fault;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_st_data, r_word, r_ld_data;

  logic        w_accept, w_fault, w_ld_upd;
  logic [31:0] w_merge, w_ext, w_word_addr;

  assign w_accept    = (r_state == S_IDLE) && i_req;
  assign w_word_addr = {r_addr[31:2], 2'b00};
  assign w_ld_upd    = (r_state == S_DONE) && !r_wr && !r_fault;

  // Fault check on the live request inputs at the accept edge
  always_comb begin
    w_fault = 1'b0;
    if (i_size == 2'b11)                          w_fault = 1'b1;
    if (i_size == 2'b01 && i_addr[0])             w_fault = 1'b1;
    if (i_size == 2'b10 && i_addr[1:0] != 2'b00)  w_fault = 1'b1;
    if ({2'b00, i_addr[31:2]} >= MEM_WORDS)       w_fault = 1'b1;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (w_fault)                        w_next = S_DONE;
          else if (i_wr && i_size == 2'b10)   w_next = S_WRITE;
          else                                w_next = S_READ;
        end
      end
      S_READ:  w_next = r_wr ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, captured memory word and held load result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr      <= 1'b0;
      r_signed  <= 1'b0;
      r_fault   <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_st_data <= '0;
      r_word    <= '0;
      r_ld_data <= '0;
    end else begin
      if (w_accept) begin
        r_wr      <= i_wr;
        r_signed  <= i_signed;
        r_fault   <= w_fault;
        r_size    <= i_size;
        r_addr    <= i_addr;
        r_st_data <= i_st_data;
      end
      if (r_state == S_READ) r_word <= i_mem_r_data;
      if (w_ld_upd)          r_ld_data <= w_ext;
    end
  end

  // Sub-word store: replace the addressed little-endian lane in the captured word
  always_comb begin
    w_merge = r_word;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merge[7:0]   = r_st_data[7:0];
        2'd1:    w_merge[15:8]  = r_st_data[7:0];
        2'd2:    w_merge[23:16] = r_st_data[7:0];
        default: w_merge[31:24] = r_st_data[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_st_data[15:0];
    end else begin
      w_merge[15:0]  = r_st_data[15:0];
    end
  end

  // Load extraction and sign/zero extension
  always_comb begin
    logic [7:0]  v_b;
    logic [15:0] v_h;
    case (r_addr[1:0])
      2'd0:    v_b = r_word[7:0];
      2'd1:    v_b = r_word[15:8];
      2'd2:    v_b = r_word[23:16];
      default: v_b = r_word[31:24];
    endcase
    v_h = r_addr[1] ? r_word[31:16] : r_word[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & v_b[7]}}, v_b};
      2'b01:   w_ext = {{16{r_signed & v_h[15]}}, v_h};
      default: w_ext = r_word;
    endcase
  end

  // Outputs decoded from state so reset drops memory strobes asynchronously
  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_DONE);
    o_fault      = (r_state == S_DONE) && r_fault;
    o_ld_data    = w_ld_upd ? w_ext : r_ld_data;
    o_mem_w_en   = 1'b0;
    o_mem_addr   = '0;
    o_mem_w_data = '0;
    if (r_state == S_READ) begin
      o_mem_addr = w_word_addr;
    end else if (r_state == S_WRITE) begin
      o_mem_w_en   = 1'b1;
      o_mem_addr   = w_word_addr;
      o_mem_w_data = (r_size == 2'b10) ? r_st_data : w_merge;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64-word memory and
// a scoreboard queue of expected completions.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0, sgn = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, st_data = '0;
  logic        busy, done, fault, mem_w_en;
  logic [31:0] ld_data, mem_addr, mem_w_data, mem_r_data;

  logic [31:0] mem [64];
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          lat;
    logic        flt;
    logic [31:0] ld;
    int          nw;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_size(size),
    .i_signed(sgn), .i_addr(addr), .i_st_data(st_data),
    .o_busy(busy), .o_done(done), .o_fault(fault), .o_ld_data(ld_data),
    .o_mem_w_en(mem_w_en), .o_mem_addr(mem_addr), .o_mem_w_data(mem_w_data),
    .i_mem_r_data(mem_r_data)
  );

  assign mem_r_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_w_en) begin
      mem[mem_addr[7:2]] <= mem_w_data;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_w_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: push expectation, drive, wait (bounded) for Done, pop and compare
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic s,
                     input logic [31:0] a, input logic [31:0] d, input int lat,
                     input logic f, input logic [31:0] ld, input int nw, input logic [31:0] wd);
    exp_t e;
    int   n;
    int   wc0;
    sb.push_back('{lat: lat, flt: f, ld: ld, nw: nw, wd: wd});
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sgn = s; addr = a; st_data = d;
    wc0 = wr_cnt;
    @(posedge clk); #1;
    req = 1'b0;
    chk({tag, ".busy_rise"}, {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({tag, ".timeout"}, 32'(n), 32'(e.lat));
    end else begin
      chk({tag, ".latency"}, 32'(n), 32'(e.lat));
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e.flt});
      chk({tag, ".ld_data"}, ld_data, e.ld);
    end
    @(posedge clk); #1;
    chk({tag, ".busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, ".writes"}, 32'(wr_cnt - wc0), 32'(e.nw));
    if (e.nw > 0) begin
      chk({tag, ".wdata"}, last_wdata, e.wd);
      chk({tag, ".waddr"}, last_waddr, {a[31:2], 2'b00});
    end
  endtask

  initial begin
    int          ndone;
    int          wc;

    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.mem_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.ld_data", ld_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // word store/load
    run("sw",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0,        1, 32'hDEADBEEF);
    run("lw",   0, 2'b10, 0, 32'h10, 32'h0,        2, 0, 32'hDEADBEEF, 0, 32'h0);
    // byte RMW
    run("sw2",  1, 2'b10, 0, 32'h10, 32'h11223344, 2, 0, 32'hDEADBEEF, 1, 32'h11223344);
    run("sb",   1, 2'b00, 0, 32'h12, 32'h000000AA, 3, 0, 32'hDEADBEEF, 1, 32'h11AA3344);
    run("lw2",  0, 2'b10, 0, 32'h10, 32'h0,        2, 0, 32'h11AA3344, 0, 32'h0);
    // extension
    run("sw3",  1, 2'b10, 0, 32'h10, 32'h80FF7F01, 2, 0, 32'h11AA3344, 1, 32'h80FF7F01);
    run("lbs1", 0, 2'b00, 1, 32'h11, 32'h0,        2, 0, 32'h0000007F, 0, 32'h0);
    run("lhs",  0, 2'b01, 1, 32'h12, 32'h0,        2, 0, 32'hFFFF80FF, 0, 32'h0);
    run("lbu3", 0, 2'b00, 0, 32'h13, 32'h0,        2, 0, 32'h00000080, 0, 32'h0);
    run("lbs3", 0, 2'b00, 1, 32'h13, 32'h0,        2, 0, 32'hFFFFFF80, 0, 32'h0);
    run("lhu",  0, 2'b01, 0, 32'h12, 32'h0,        2, 0, 32'h000080FF, 0, 32'h0);
    run("sh",   1, 2'b01, 0, 32'h12, 32'hABCD1234, 3, 0, 32'h000080FF, 1, 32'h12347F01);
    // faults leave Ld_Data alone and never write
    run("f_lh", 0, 2'b01, 1, 32'h11, 32'h0,        1, 1, 32'h000080FF, 0, 32'h0);
    run("f_sw", 1, 2'b10, 0, 32'h12, 32'h5A5A5A5A, 1, 1, 32'h000080FF, 0, 32'h0);
    run("f_sz", 0, 2'b11, 0, 32'h10, 32'h0,        1, 1, 32'h000080FF, 0, 32'h0);
    run("f_rg", 0, 2'b10, 0, 32'h100, 32'h0,       1, 1, 32'h000080FF, 0, 32'h0);
    run("f_sb", 1, 2'b00, 0, 32'h101, 32'h77,      1, 1, 32'h000080FF, 0, 32'h0);
    // last valid word
    run("sw_t", 1, 2'b10, 0, 32'hFC, 32'h0BADF00D, 2, 0, 32'h000080FF, 1, 32'h0BADF00D);
    run("lb_t", 0, 2'b00, 1, 32'hFF, 32'h0,        2, 0, 32'h0000000B, 0, 32'h0);

    // Req held high: accepted at edges 0 and 3 only (through READ and DONE)
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h10;
    ndone = 0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done) ndone++;
      if (k == 1) chk("hold.ld1", ld_data, 32'h12347F01);
      if (k == 5) req = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("hold.dones", 32'(ndone), 32'd2);
    chk("hold.idle", {31'd0, busy}, 32'd0);

    // Reset during WRITE of a sub-word store
    run("sw5",  1, 2'b10, 0, 32'h14, 32'hCAFEBABE, 2, 0, 32'h12347F01, 1, 32'hCAFEBABE);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h14; st_data = 32'h55;
    wc = wr_cnt;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("rstw.w_en_before", {31'd0, mem_w_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw.w_en_after", {31'd0, mem_w_en}, 32'd0);
    chk("rstw.busy", {31'd0, busy}, 32'd0);
    chk("rstw.ld_clr", ld_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.nowrite", 32'(wr_cnt - wc), 32'd0);
    run("lw5",  0, 2'b10, 0, 32'h14, 32'h0,        2, 0, 32'hCAFEBABE, 0, 32'h0);
    run("sb5",  1, 2'b00, 0, 32'h15, 32'h55,       3, 0, 32'hCAFEBABE, 1, 32'hCAFE55BE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
